// File: rtl/mem_arbiter_pkg.sv
// Shared types for the SRAM port arbiter: FSM states, requester indices, request record.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// The request record is sized by the package widths. mem_arbiter casts its ADDR_W/DATA_W
// ports into and out of this record, so the package widths set the ceiling.
package mem_arbiter_pkg;

  localparam int REQ_ADDR_W = 16;
  localparam int REQ_DATA_W = 16;
  localparam int STARVE_W   = 8;   // holds STARVE_MAX up to 255

  localparam int N_REQ    = 3;
  localparam int REQ_BOOT = 0;
  localparam int REQ_DBG  = 1;
  localparam int REQ_CORE = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic                  wr;
    logic [REQ_ADDR_W-1:0] addr;
    logic [REQ_DATA_W-1:0] data;
  } req_t;

endpackage

// File: rtl/mem_arbiter_pick.sv
// Winner selection: fixed priority boot > dbg > core, with a starvation override for the core.
// Latency: combinational.
// Backpressure: none; losers are not told, they simply keep requesting.
// Ports:
//   req        : request vector indexed by REQ_BOOT/REQ_DBG/REQ_CORE
//   starve_cnt : lost-arbitration count of the core
//   grant      : one-hot winner, all zero when nobody requests
module mem_arbiter_pick
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 8
) (
  input  logic [N_REQ-1:0]    req,
  input  logic [STARVE_W-1:0] starve_cnt,
  output logic [N_REQ-1:0]    grant
);

  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  logic core_forced;

  // The core only jumps the queue once it has lost STARVE_MAX times in a row.
  assign core_forced = req[REQ_CORE] && (starve_cnt == STARVE_LIM);

  always_comb begin
    grant = '0;
    if (core_forced) begin
      grant[REQ_CORE] = 1'b1;
    end else if (req[REQ_BOOT]) begin
      grant[REQ_BOOT] = 1'b1;
    end else if (req[REQ_DBG]) begin
      grant[REQ_DBG] = 1'b1;
    end else if (req[REQ_CORE]) begin
      grant[REQ_CORE] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one SRAM port between boot loader, JTAG debug and core, one access at a time.
// Latency: request seen in IDLE (cycle 0) -> SRAM driven (cycle 1) -> ack pulse (cycle 2).
// Backpressure: requesters hold req until their ack; one access per 3 cycles.
// Ports:
//   i_clk, i_rstn                : clock, asynchronous active-low reset
//   i_{boot,dbg,core}{Req,Wr,Addr,Data} : requester inputs, held until ack
//   o_{boot,dbg,core}Ack         : one-cycle completion pulse
//   o_rdData                     : shared read data, valid in the ack cycle
//   o_memAddr/o_memData/o_memWr/o_memEn, i_memData : SRAM port
// Optional: MEM_ARBITER_STATS_EN adds o_{boot,dbg,core}Cnt saturating ack counters.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int STARVE_MAX = 8
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_bootReq,
  input  logic              i_bootWr,
  input  logic [ADDR_W-1:0] i_bootAddr,
  input  logic [DATA_W-1:0] i_bootData,
  input  logic              i_dbgReq,
  input  logic              i_dbgWr,
  input  logic [ADDR_W-1:0] i_dbgAddr,
  input  logic [DATA_W-1:0] i_dbgData,
  input  logic              i_coreReq,
  input  logic              i_coreWr,
  input  logic [ADDR_W-1:0] i_coreAddr,
  input  logic [DATA_W-1:0] i_coreData,
  output logic              o_bootAck,
  output logic              o_dbgAck,
  output logic              o_coreAck,
  output logic [DATA_W-1:0] o_rdData,
  output logic [ADDR_W-1:0] o_memAddr,
  output logic [DATA_W-1:0] o_memData,
  input  logic [DATA_W-1:0] i_memData,
  output logic              o_memWr,
  output logic              o_memEn
`ifdef MEM_ARBITER_STATS_EN
  ,
  output logic [15:0]       o_bootCnt,
  output logic [15:0]       o_dbgCnt,
  output logic [15:0]       o_coreCnt
`endif
);

  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  arb_state_t          state, state_nxt;
  logic [N_REQ-1:0]    req_vec;
  logic [N_REQ-1:0]    grant;
  logic [N_REQ-1:0]    grant_q;
  logic [STARVE_W-1:0] starve_cnt;
  req_t                cap_sel;
  req_t                cap_q;
  logic [DATA_W-1:0]   rd_q;
  logic                arb_now;
  logic                core_lost;

  assign req_vec[REQ_BOOT] = i_bootReq;
  assign req_vec[REQ_DBG]  = i_dbgReq;
  assign req_vec[REQ_CORE] = i_coreReq;

  mem_arbiter_pick #(
    .STARVE_MAX (STARVE_MAX)
  ) u_pick (
    .req        (req_vec),
    .starve_cnt (starve_cnt),
    .grant      (grant)
  );

  // Arbitration happens only in IDLE; later changes on the request lines are ignored
  // because the winner's fields are captured here.
  assign arb_now   = (state == IDLE) && (|req_vec);
  assign core_lost = req_vec[REQ_CORE] && !grant[REQ_CORE];

  always_comb begin
    cap_sel = '0;
    if (grant[REQ_BOOT]) begin
      cap_sel.wr   = i_bootWr;
      cap_sel.addr = REQ_ADDR_W'(i_bootAddr);
      cap_sel.data = REQ_DATA_W'(i_bootData);
    end else if (grant[REQ_DBG]) begin
      cap_sel.wr   = i_dbgWr;
      cap_sel.addr = REQ_ADDR_W'(i_dbgAddr);
      cap_sel.data = REQ_DATA_W'(i_dbgData);
    end else if (grant[REQ_CORE]) begin
      cap_sel.wr   = i_coreWr;
      cap_sel.addr = REQ_ADDR_W'(i_coreAddr);
      cap_sel.data = REQ_DATA_W'(i_coreData);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req_vec) state_nxt = ACCESS;
      ACCESS:  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      cap_q   <= '0;
      grant_q <= '0;
    end else if (arb_now) begin
      cap_q   <= cap_sel;
      grant_q <= grant;
    end
  end

  // Counts consecutive lost arbitrations of a requesting core; idle core leaves it alone.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      starve_cnt <= '0;
    end else if (arb_now) begin
      if (grant[REQ_CORE]) begin
        starve_cnt <= '0;
      end else if (core_lost && (starve_cnt != STARVE_LIM)) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

  // Read data is captured at the edge that closes ACCESS and held until the next read.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      rd_q <= '0;
    end else if ((state == ACCESS) && !cap_q.wr) begin
      rd_q <= i_memData;
    end
  end

  // Strobes decode straight from the state register so an asynchronous reset
  // drops them in the same cycle.
  assign o_memEn   = (state == ACCESS);
  assign o_memWr   = (state == ACCESS) && cap_q.wr;
  assign o_memAddr = ADDR_W'(cap_q.addr);
  assign o_memData = DATA_W'(cap_q.data);
  assign o_rdData  = rd_q;

  assign o_bootAck = (state == DONE) && grant_q[REQ_BOOT];
  assign o_dbgAck  = (state == DONE) && grant_q[REQ_DBG];
  assign o_coreAck = (state == DONE) && grant_q[REQ_CORE];

`ifdef MEM_ARBITER_STATS_EN
  logic [15:0] boot_cnt_q, dbg_cnt_q, core_cnt_q;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      boot_cnt_q <= '0;
      dbg_cnt_q  <= '0;
      core_cnt_q <= '0;
    end else begin
      if (o_bootAck && (boot_cnt_q != 16'hFFFF)) boot_cnt_q <= boot_cnt_q + 16'd1;
      if (o_dbgAck  && (dbg_cnt_q  != 16'hFFFF)) dbg_cnt_q  <= dbg_cnt_q  + 16'd1;
      if (o_coreAck && (core_cnt_q != 16'hFFFF)) core_cnt_q <= core_cnt_q + 16'd1;
    end
  end

  assign o_bootCnt = boot_cnt_q;
  assign o_dbgCnt  = dbg_cnt_q;
  assign o_coreCnt = core_cnt_q;
`else
  // Statistics build option off: no counters exist.
`endif

endmodule
